nemesis_68k_dtack: RTL and testbench
====================================

# nemesis_68k_dtack

Bus-cycle acknowledge generator for the Nemesis 68000. Sits directly downstream of the 68k address decoder. It consumes the decoder's active-low chip selects together with the CPU strobes, and sequences one acknowledge per bus cycle, in one of four ways:
- zero-wait for work RAM and external
- SDRAM-handshaked wait for PROM and character ROM
- arbitration wait for video RAM
- fixed wait states for I/O

A timeout watchdog drives BERR on unmapped or stuck cycles.

## Interface
Parameters:
- IO_WAIT, 2, CPU-enable cycles inserted before DTACK on I/O cycles (0–15)
- TIMEOUT, 255, CPU-enable cycles before BERR in wait states (1–255)

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_cpu_cen  in  1  68k clock-enable pulse; state advances only on these edges, except where noted
- i_as_n  in  1  CPU address strobe
- i_prom_cs_n  in  1  program ROM select
- i_chara_n  in  1  character ROM select
- i_ram_cs_n  in  1  work RAM select
- i_excs_n  in  1  external select
- i_vid_cs_n  in  1  AND of the vzure/vramcs1/vramcs2/objram/color_ram selects
- i_io_cs_n  in  1  AND of the data/afe/input mux/dip/u11k/u13j selects
- i_rom_ok  in  1  SDRAM read data valid; may be a one-clock pulse
- i_vid_busy  in  1  video scan currently owns the VRAM port
- o_dtack_n  out  1  data acknowledge to CPU
- o_berr_n  out  1  bus error to CPU
- o_rom_req  out  1  SDRAM read request, held for the ROM wait

## Operation
- States:
  - IDLE
  - ROM
  - VID
  - IO
  - UNMAP
  - ACK
  - BERR
- Reset:
  - state IDLE
  - o_dtack_n=1, o_berr_n=1, o_rom_req=0
  - counters 0, rom_ok flag 0
- IDLE, on a cen edge with i_as_n=0, selects are decoded in priority order: prom > chara > ram > excs > vid > io. Simultaneous selects are illegal upstream, but this priority is still binding.
  - ram or excs: go to ACK; o_dtack_n<=0 on the same edge.
  - prom or chara: go to ROM; o_rom_req<=1; rom_ok flag cleared.
  - vid: go to VID.
  - io: go to IO with wait counter = IO_WAIT. If IO_WAIT=0, go directly to ACK.
  - no select: go to UNMAP.
- ROM:
  - i_rom_ok sets a sticky flag on any clk edge.
  - On a cen edge with the flag set: go to ACK and drop o_rom_req.
- VID: on a cen edge with i_vid_busy=0, go to ACK.
- IO: on each cen edge the counter decrements; the edge where it goes 1→0 also enters ACK.
- Timeout counter:
  - Counts cen edges in ROM, VID and UNMAP; saturates.
  - When it reaches TIMEOUT: go to BERR with o_berr_n<=0. o_rom_req drops.
  - Timeout takes precedence over a same-edge ack condition.
- ACK and BERR hold their strobe low until AS is released.
- AS release: on any clk edge (not only cen) with i_as_n=1 in a non-IDLE state:
  - state returns to IDLE
  - o_dtack_n=1, o_berr_n=1, o_rom_req=0
  - both counters and the rom_ok flag cleared
- Reset mid-cycle: all outputs return to reset values immediately (asynchronous). The cycle is abandoned.
- Chip selects are sampled only in IDLE. Changes later in the cycle are ignored.

## Timing
- All outputs are registered, with no combinational path from input to output.
- RAM/excs: DTACK is low after the first cen edge that sees AS low (zero wait).
- IO: DTACK is low IO_WAIT cen edges after the decode edge.
- ROM:
  - o_rom_req rises at the decode edge.
  - DTACK is low at the first cen edge at or after the clock following i_rom_ok.
- VID: DTACK is low at the first cen edge with i_vid_busy=0, starting from the edge after decode.
- Strobe release latency is one clk after AS rises.

## Structure
- Shared package nemesis_bus_pkg holds:
  - state encoding localparams: IDLE=0, ROM, VID, IO, UNMAP, ACK, BERR
  - default IO_WAIT and TIMEOUT constants
- One natural sub-module: nemesis_wait_cnt, a loadable cen-gated down/up counter with a saturate flag. It is instantiated twice, once for the I/O wait and once for the timeout.

## Test plan
- Work RAM read: AS low with ram_cs_n=0 at cen edge k → o_dtack_n=0 after edge k. AS high → o_dtack_n=1 one clk later.
- I/O with IO_WAIT=2: io_cs_n=0 at edge k → o_dtack_n=1 through edge k+1, 0 after edge k+2.
- PROM: prom_cs_n=0 → o_rom_req=1. A one-clk i_rom_ok pulse lands between cen edges → DTACK at the next cen edge and o_rom_req=0 at that edge.
- VRAM contention: i_vid_busy=1 for 5 cen edges after decode → DTACK on the 6th edge, with o_berr_n staying 1.
- Unmapped access with TIMEOUT=4: no select → o_berr_n=0 after the 4th cen edge in UNMAP, and DTACK never asserts.
- Reset asserted in ROM with o_rom_req=1 → o_rom_req=0, o_dtack_n=1, o_berr_n=1 immediately. After release, a RAM cycle acks with zero wait.

Source files
------------

// File: rtl/nemesis_bus_pkg.sv
// Shared definitions for the Nemesis 68000 bus-cycle acknowledge logic:
// bus-cycle state encoding and default wait/timeout settings.
package nemesis_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ROM   = 3'd1,
        ST_VID   = 3'd2,
        ST_IO    = 3'd3,
        ST_UNMAP = 3'd4,
        ST_ACK   = 3'd5,
        ST_BERR  = 3'd6
    } bus_state_e;

    localparam int IO_WAIT_DEF = 2;
    localparam int TIMEOUT_DEF = 255;
    localparam int CNT_W       = 8;

endpackage

// File: rtl/nemesis_wait_cnt.sv
// Loadable, cen-gated up/down counter that sticks at its end value
// (all-ones counting up, zero counting down) and flags that condition.
module nemesis_wait_cnt #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_cen,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    input  logic         i_up,
    output logic [W-1:0] o_cnt,
    output logic         o_sat
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign o_sat = i_up ? (cnt_q == {W{1'b1}}) : (cnt_q == {W{1'b0}});
    assign o_cnt = cnt_q;

    // Clear and load act on any clock; counting only on enable pulses.
    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_load) begin
            cnt_d = i_load_val;
        end else if (i_cen && i_en && !o_sat) begin
            cnt_d = i_up ? (cnt_q + W'(1)) : (cnt_q - W'(1));
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/nemesis_68k_dtack.sv
// Nemesis 68000 bus-cycle acknowledge generator: turns decoded chip selects
// and AS into one registered DTACK (or BERR on timeout) per bus cycle.
module nemesis_68k_dtack
    import nemesis_bus_pkg::*;
#(
    parameter int IO_WAIT = IO_WAIT_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_cpu_cen,
    input  logic i_as_n,
    input  logic i_prom_cs_n,
    input  logic i_chara_n,
    input  logic i_ram_cs_n,
    input  logic i_excs_n,
    input  logic i_vid_cs_n,
    input  logic i_io_cs_n,
    input  logic i_rom_ok,
    input  logic i_vid_busy,
    output logic o_dtack_n,
    output logic o_berr_n,
    output logic o_rom_req
);

    localparam logic [CNT_W-1:0] IO_LD   = CNT_W'(IO_WAIT);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    bus_state_e       state_q, state_d;
    logic             rom_ok_q, rom_ok_d;
    logic             dtack_n_q, berr_n_q, rom_req_q;

    logic             as_release;
    logic             io_load, to_load;
    logic             io_en, to_en;
    logic [CNT_W-1:0] io_cnt, to_cnt;
    logic             io_sat, to_sat;
    logic             io_done, to_hit;

    assign as_release = i_as_n && (state_q != ST_IDLE);
    assign io_en      = (state_q == ST_IO);
    assign to_en      = (state_q == ST_ROM) || (state_q == ST_VID) || (state_q == ST_UNMAP);

    // io_done fires on the enable pulse that takes the wait count from 1 to 0.
    assign io_done = i_cpu_cen && ((io_cnt == CNT_W'(1)) || io_sat);
    assign to_hit  = i_cpu_cen && to_en && ((to_cnt == TO_LAST) || to_sat);

    nemesis_wait_cnt #(.W(CNT_W)) u_io_cnt (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_cen      (i_cpu_cen),
        .i_clr      (as_release),
        .i_load     (io_load),
        .i_load_val (IO_LD),
        .i_en       (io_en),
        .i_up       (1'b0),
        .o_cnt      (io_cnt),
        .o_sat      (io_sat)
    );

    nemesis_wait_cnt #(.W(CNT_W)) u_to_cnt (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_cen      (i_cpu_cen),
        .i_clr      (as_release),
        .i_load     (to_load),
        .i_load_val ({CNT_W{1'b0}}),
        .i_en       (to_en),
        .i_up       (1'b1),
        .o_cnt      (to_cnt),
        .o_sat      (to_sat)
    );

    always_comb begin
        state_d  = state_q;
        rom_ok_d = rom_ok_q;
        io_load  = 1'b0;
        to_load  = 1'b0;
        if (as_release) begin
            state_d  = ST_IDLE;
            rom_ok_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (i_cpu_cen && !i_as_n) begin
                        if (!i_prom_cs_n || !i_chara_n) begin
                            state_d  = ST_ROM;
                            rom_ok_d = 1'b0;
                            to_load  = 1'b1;
                        end else if (!i_ram_cs_n || !i_excs_n) begin
                            state_d = ST_ACK;
                        end else if (!i_vid_cs_n) begin
                            state_d = ST_VID;
                            to_load = 1'b1;
                        end else if (!i_io_cs_n) begin
                            state_d = (IO_WAIT == 0) ? ST_ACK : ST_IO;
                            io_load = 1'b1;
                        end else begin
                            state_d = ST_UNMAP;
                            to_load = 1'b1;
                        end
                    end
                end
                ST_ROM: begin
                    // The flag is registered, so a pulse is acted on no earlier than the next clock.
                    if (i_rom_ok) begin
                        rom_ok_d = 1'b1;
                    end
                    if (to_hit) begin
                        state_d = ST_BERR;
                    end else if (i_cpu_cen && rom_ok_q) begin
                        state_d = ST_ACK;
                    end
                end
                ST_VID: begin
                    if (to_hit) begin
                        state_d = ST_BERR;
                    end else if (i_cpu_cen && !i_vid_busy) begin
                        state_d = ST_ACK;
                    end
                end
                ST_IO: begin
                    if (io_done) begin
                        state_d = ST_ACK;
                    end
                end
                ST_UNMAP: begin
                    if (to_hit) begin
                        state_d = ST_BERR;
                    end
                end
                ST_ACK, ST_BERR: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Strobes are registered from the next state so they change on the entry edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            rom_ok_q  <= 1'b0;
            dtack_n_q <= 1'b1;
            berr_n_q  <= 1'b1;
            rom_req_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rom_ok_q  <= rom_ok_d;
            dtack_n_q <= (state_d != ST_ACK);
            berr_n_q  <= (state_d != ST_BERR);
            rom_req_q <= (state_d == ST_ROM);
        end
    end

    assign o_dtack_n = dtack_n_q;
    assign o_berr_n  = berr_n_q;
    assign o_rom_req = rom_req_q;

endmodule

// File: tb/tb_nemesis_68k_dtack.sv
// Bench for nemesis_68k_dtack: two parameterisations driven in parallel,
// checked against a per-bus-cycle reference model with directed and random cycles.
module tb_nemesis_68k_dtack;

    localparam logic [5:0] CS_NONE = 6'b111111;
    localparam logic [5:0] CS_PROM = 6'b011111;
    localparam logic [5:0] CS_RAM  = 6'b110111;
    localparam logic [5:0] CS_VID  = 6'b111101;
    localparam logic [5:0] CS_IO   = 6'b111110;

    localparam int K_ROM = 0, K_FAST = 1, K_VID = 2, K_IO = 3, K_UNMAP = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cen = 1'b0;
    logic       as_n = 1'b1;
    logic [5:0] cs_n = CS_NONE;
    logic       rom_ok = 1'b0;
    logic       vid_busy = 1'b0;
    logic [1:0] dtack_n, berr_n, rom_req;

    int n_chk = 0;
    int n_err = 0;

    int iow [2] = '{2, 0};
    int tmo [2] = '{255, 4};

    // Reference model, one slot per DUT: is a bus cycle in progress, what kind,
    // outcome so far (0 waiting, 1 acked, 2 bus error), and wait bookkeeping.
    int m_act [2];
    int m_kind [2];
    int m_res [2];
    int m_tc [2];
    int m_io [2];
    int m_ok [2];

    always #5 clk = ~clk;

    nemesis_68k_dtack #(.IO_WAIT(2), .TIMEOUT(255)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_cpu_cen(cen), .i_as_n(as_n),
        .i_prom_cs_n(cs_n[5]), .i_chara_n(cs_n[4]), .i_ram_cs_n(cs_n[3]),
        .i_excs_n(cs_n[2]), .i_vid_cs_n(cs_n[1]), .i_io_cs_n(cs_n[0]),
        .i_rom_ok(rom_ok), .i_vid_busy(vid_busy),
        .o_dtack_n(dtack_n[0]), .o_berr_n(berr_n[0]), .o_rom_req(rom_req[0])
    );

    nemesis_68k_dtack #(.IO_WAIT(0), .TIMEOUT(4)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_cpu_cen(cen), .i_as_n(as_n),
        .i_prom_cs_n(cs_n[5]), .i_chara_n(cs_n[4]), .i_ram_cs_n(cs_n[3]),
        .i_excs_n(cs_n[2]), .i_vid_cs_n(cs_n[1]), .i_io_cs_n(cs_n[0]),
        .i_rom_ok(rom_ok), .i_vid_busy(vid_busy),
        .o_dtack_n(dtack_n[1]), .o_berr_n(berr_n[1]), .o_rom_req(rom_req[1])
    );

    task automatic chk(input string tag, input logic got, input logic exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0b exp=%0b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_act[i] = 0; m_kind[i] = K_UNMAP; m_res[i] = 0;
            m_tc[i] = 0; m_io[i] = 0; m_ok[i] = 0;
        end
    endtask

    function automatic int decode_kind(input logic [5:0] cs);
        if (!cs[5] || !cs[4]) return K_ROM;
        if (!cs[3] || !cs[2]) return K_FAST;
        if (!cs[1])           return K_VID;
        if (!cs[0])           return K_IO;
        return K_UNMAP;
    endfunction

    // Advance the model by one clock, using the inputs present at that edge.
    task automatic model_step(input int i);
        if (m_act[i] != 0) begin
            if (as_n) begin
                m_act[i] = 0; m_res[i] = 0; m_tc[i] = 0; m_io[i] = 0; m_ok[i] = 0;
            end else if (m_res[i] == 0) begin
                if (cen) begin
                    if (m_kind[i] == K_IO) begin
                        m_io[i]--;
                        if (m_io[i] == 0) m_res[i] = 1;
                    end else begin
                        m_tc[i]++;
                        if (m_tc[i] == tmo[i]) m_res[i] = 2;
                        else if (m_kind[i] == K_ROM && m_ok[i] != 0) m_res[i] = 1;
                        else if (m_kind[i] == K_VID && !vid_busy) m_res[i] = 1;
                    end
                end
                if (m_kind[i] == K_ROM && rom_ok) m_ok[i] = 1;
            end
        end else if (cen && !as_n) begin
            m_act[i]  = 1;
            m_kind[i] = decode_kind(cs_n);
            m_res[i]  = 0; m_tc[i] = 0; m_ok[i] = 0;
            if (m_kind[i] == K_FAST) m_res[i] = 1;
            if (m_kind[i] == K_IO) begin
                m_io[i] = iow[i];
                if (iow[i] == 0) m_res[i] = 1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s.dtack%0d", tag, i), dtack_n[i], !(m_act[i] != 0 && m_res[i] == 1));
            chk($sformatf("%s.berr%0d", tag, i), berr_n[i], !(m_act[i] != 0 && m_res[i] == 2));
            chk($sformatf("%s.req%0d", tag, i), rom_req[i],
                (m_act[i] != 0 && m_res[i] == 0 && m_kind[i] == K_ROM));
        end
    endtask

    task automatic tick(input logic c, input logic a, input logic [5:0] cs,
                        input logic ok, input logic b, input string tag);
        cen = c; as_n = a; cs_n = cs; rom_ok = ok; vid_busy = b;
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        check_all(tag);
    endtask

    // Reset pulse entirely between clock edges, so only the asynchronous path can act.
    task automatic pulse_reset(input string tag);
        #1 rst_n = 1'b0;
        #1 model_reset();
        check_all(tag);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        logic [5:0] cs_r;
        int as_left;
        logic as_r;
        model_reset();
        repeat (3) @(posedge clk);
        #1 check_all("reset");
        rst_n = 1'b1;

        tick(0, 1, CS_NONE, 0, 0, "idle");
        tick(1, 0, CS_RAM, 0, 0, "ram_dec");
        chk("ram_dtack_lo", dtack_n[0], 1'b0);
        tick(0, 1, CS_NONE, 0, 0, "ram_rel");
        chk("ram_dtack_rel", dtack_n[0], 1'b1);

        tick(1, 0, CS_IO, 0, 0, "io_k");
        chk("io_k_a", dtack_n[0], 1'b1);
        chk("io_k_b_nowait", dtack_n[1], 1'b0);
        tick(1, 0, CS_IO, 0, 0, "io_k1");
        chk("io_k1_a", dtack_n[0], 1'b1);
        tick(0, 0, CS_IO, 0, 0, "io_gap");
        tick(1, 0, CS_IO, 0, 0, "io_k2");
        chk("io_k2_a", dtack_n[0], 1'b0);
        tick(0, 1, CS_NONE, 0, 0, "io_rel");

        tick(1, 0, CS_PROM, 0, 0, "rom_dec");
        chk("rom_req_hi", rom_req[0], 1'b1);
        tick(0, 0, CS_NONE, 1, 0, "rom_okpulse");
        chk("rom_wait_dtack", dtack_n[0], 1'b1);
        tick(0, 0, CS_NONE, 0, 0, "rom_gap");
        tick(1, 0, CS_NONE, 0, 0, "rom_ack");
        chk("rom_ack_dtack", dtack_n[0], 1'b0);
        chk("rom_ack_req", rom_req[0], 1'b0);
        tick(0, 1, CS_NONE, 0, 0, "rom_rel");

        tick(1, 0, CS_VID, 0, 1, "vid_dec");
        for (int k = 1; k <= 5; k++) begin
            tick(1, 0, CS_NONE, 0, 1, "vid_busy");
            chk("vid_busy_dtack", dtack_n[0], 1'b1);
        end
        tick(1, 0, CS_NONE, 0, 0, "vid_free");
        chk("vid_ack_dtack", dtack_n[0], 1'b0);
        chk("vid_ack_berr", berr_n[0], 1'b1);
        chk("vid_b_timeout", berr_n[1], 1'b0);
        tick(0, 1, CS_NONE, 0, 0, "vid_rel");

        tick(1, 0, CS_NONE, 0, 0, "unmap_dec");
        for (int k = 1; k <= 4; k++) begin
            tick(1, 0, CS_NONE, 0, 0, "unmap");
            if (k == 3) chk("unmap_b_berr_early", berr_n[1], 1'b1);
        end
        chk("unmap_b_berr", berr_n[1], 1'b0);
        tick(1, 0, CS_NONE, 0, 0, "unmap_hold");
        chk("unmap_b_dtack", dtack_n[1], 1'b1);
        tick(0, 1, CS_NONE, 0, 0, "unmap_rel");
        chk("unmap_b_berr_rel", berr_n[1], 1'b1);

        tick(1, 0, CS_PROM, 0, 0, "rst_rom_dec");
        chk("rst_rom_req", rom_req[0], 1'b1);
        pulse_reset("rst_mid");
        chk("rst_req_lo", rom_req[0], 1'b0);
        chk("rst_dtack_hi", dtack_n[0], 1'b1);
        chk("rst_berr_hi", berr_n[0], 1'b1);
        tick(1, 0, CS_RAM, 0, 0, "rst_ram");
        chk("rst_ram_dtack", dtack_n[0], 1'b0);
        tick(0, 1, CS_NONE, 0, 0, "rst_rel");

        as_r = 1'b1;
        as_left = 2;
        for (int t = 0; t < 4000; t++) begin
            if (as_left == 0) begin
                as_r = ~as_r;
                as_left = as_r ? $urandom_range(1, 3) : $urandom_range(1, 40);
            end
            as_left--;
            case ($urandom_range(0, 7))
                0: cs_r = CS_PROM;
                1: cs_r = 6'b101111;
                2: cs_r = CS_RAM;
                3: cs_r = 6'b111011;
                4: cs_r = CS_VID;
                5: cs_r = CS_IO;
                6: cs_r = CS_NONE;
                default: cs_r = 6'($urandom);
            endcase
            tick(1'($urandom_range(0, 1)), as_r, cs_r,
                 ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), "rand");
            if ($urandom_range(0, 299) == 0) pulse_reset("rand_rst");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
